regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Front-end access controller that drives the 16-lane, 32-register, 32-bit-per-lane `register_block` (two read ports, one write port, one shared `warp_selector`). It takes operand-fetch requests from the issue stage and lane-masked writebacks from execute, and arbitrates them onto the shared `warp_selector`. It returns a registered operand bundle over a valid/ready handshake.

## Interface
Parameters:
- `LANES`, 16, lanes per warp.
- `DW`, 32, data bits per lane.
- `AW`, 5, register address width.
- `WW`, 4, warp-id width.
- `WB_STREAK_MAX`, 4, maximum consecutive write grants while a read is pending. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `iss_valid` / `iss_ready`  in / out  1 / 1  operand-fetch request handshake.
- `iss_warp`, `iss_rs1`, `iss_rs2`, `iss_mask`  in  WW, AW, AW, LANES  fetch warp, source registers, lane mask.
- `wb_valid` / `wb_ready`  in / out  1 / 1  writeback handshake.
- `wb_warp`, `wb_rd`, `wb_mask`, `wb_data`  in  WW, AW, LANES, LANES*DW  writeback warp, destination, lane mask, data (lane i at bits [i*DW +: DW]).
- `rb_warp_selector`  out  WW  to `register_block`.
- `rb_read_en_0`, `rb_read_en_1`, `rb_write_en`  out  LANES each  per-lane enables.
- `rb_raddr_0`, `rb_raddr_1`, `rb_waddr`  out  AW each  register addresses.
- `rb_wdata`  out  LANES*DW  write data.
- `rb_rdata_0`, `rb_rdata_1`  in  LANES*DW  combinational read data.
- `opr_valid` / `opr_ready`  out / in  1 / 1  operand output handshake.
- `opr_warp`, `opr_mask`, `opr_a`, `opr_b`  out  WW, LANES, LANES*DW, LANES*DW  registered operand bundle.

## Operation

Each cycle the arbiter grants at most one of WRITE or READ, because `warp_selector` is shared.

- **Grants.**
  - `rd_ok = iss_valid && (!opr_valid || opr_ready)`.
  - Default priority is WRITE when `wb_valid`.
  - READ wins instead when `rd_ok` and `streak == WB_STREAK_MAX`.
  - Otherwise READ is granted when `rd_ok` and there is no `wb_valid`.
- **WRITE grant.**
  - `wb_ready` = 1.
  - `rb_warp_selector` = `wb_warp`, `rb_waddr` = `wb_rd`, `rb_write_en` = `wb_mask`, `rb_wdata` = `wb_data`.
  - Read enables are 0.
  - The register file updates on the same rising edge.
- **READ grant.**
  - `iss_ready` = 1.
  - `rb_warp_selector` = `iss_warp`, `rb_raddr_0` = `iss_rs1`, `rb_raddr_1` = `iss_rs2`.
  - `rb_read_en_0` = `rb_read_en_1` = `iss_mask`.
  - On that rising edge, the output register captures `rb_rdata_0` / `rb_rdata_1`. Lanes with a 0 in `iss_mask` are forced to zero.
  - The output register also captures `iss_warp` and `iss_mask`, and `opr_valid` is set to 1.
- **No grant.** All `rb_*_en` are 0; `rb_warp_selector`, `rb_raddr_*`, `rb_waddr` and `rb_wdata` hold their last driven values.
- **Streak counter** (4 bits):
  - increments on a WRITE grant while `iss_valid`;
  - clears on a READ grant or when `!iss_valid`;
  - saturates at `WB_STREAK_MAX`.
- **Output register.** `opr_valid` clears on `opr_valid && opr_ready` unless a READ grant reloads it in the same cycle. A pop and a push in the same cycle give back-to-back throughput.
- **No RAW hazard.** A write completes at the edge that ends its grant cycle, and any read of that register is granted in a later cycle, so the read observes the new value.

## Timing
- **Operand latency:** `iss_valid && iss_ready` in cycle t gives `opr_valid` = 1 in cycle t+1.
- **Throughput:** one read per cycle, or one write per cycle, with no write traffic or no read traffic respectively.
- **Write latency:** the data is visible to a read granted in cycle t+1.
- **Starvation bound:** a pending read with a non-full output is granted within `WB_STREAK_MAX`+1 cycles.
- **Reset (`rst` = 1, asynchronous):**
  - `opr_valid` = 0; `opr_warp`, `opr_mask`, `opr_a`, `opr_b` = 0; `streak` = 0.
  - `iss_ready` = `wb_ready` = 0; all `rb_*_en` = 0.
  - `rb_warp_selector`, `rb_raddr_*`, `rb_waddr` = 0; `rb_wdata` = 0.
- **Reset mid-operation:** an in-flight operand is discarded and nothing is partially written.
- **Output full with `opr_ready` = 0:** reads stall with `iss_ready` = 0. Writes continue.
- **Handshake rule:** inputs are held while valid and not ready. A `*_ready` signal never depends combinationally on `opr_ready` in a way that creates a loop (it depends only on `opr_ready`, `opr_valid` and the `*_valid` signals).

## Configuration
- `RAC_SAME_WARP_DUAL_EN`
  - **Defined:** READ and WRITE are granted together when all of the following hold:
    - `wb_valid && rd_ok`;
    - `wb_warp == iss_warp`;
    - `wb_rd != iss_rs1` and `wb_rd != iss_rs2`, or `(wb_mask & iss_mask) == 0`.
  - **Defined:** a dual grant clears `streak`.
  - **Undefined:** grants are strictly exclusive as described in Operation.

## Test plan
- **Reset:** assert `rst` during an active write (`wb_valid` = 1, `wb_mask` = FFFF) → `rb_write_en` = 0000 immediately, and after release `opr_valid` = 0 and `streak` = 0.
- **Write then read:**
  - Step 1: write warp 3, r7, mask FFFF, lane i = 0xA5A50000+i.
  - Step 2: next cycle, fetch warp 3, rs1 = rs2 = 7, mask FFFF.
  - Required: the following cycle `opr_valid` = 1, and `opr_a` lane i = `opr_b` lane i = 0xA5A50000+i.
- **Masked fetch:** fetch with mask 00FF → lanes 8..15 of `opr_a` / `opr_b` = 0, and lanes 0..7 match the stored data.
- **Starvation:** `wb_valid` held 1 and `iss_valid` held 1, with `WB_STREAK_MAX` = 4 → the write/read grant pattern is W W W W R repeating. `wb_ready` = 0 in every fifth cycle.
- **Back-pressure:** hold `opr_ready` = 0 after one operand is delivered → `iss_ready` = 0 and the output bundle is stable. Writes still complete. Raising `opr_ready` with `iss_valid` = 1 pops and reloads in the same cycle.
- **Dual grant (`RAC_SAME_WARP_DUAL_EN`):**
  - Same warp 2, write r4, read r5/r6 → both `wb_ready` and `iss_ready` = 1 in the same cycle.
  - Write r5 with a read of r5 on overlapping lanes → exclusive grants, and the read returns the new data.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitrates operand fetches and lane-masked writebacks onto the shared register_block warp_selector.
// Latency: operand bundle is registered, valid the cycle after the fetch handshake; writes land on the grant edge.
// Backpressure: a full, unpopped operand register stalls fetches (iss_ready=0) while writes continue; macro RAC_SAME_WARP_DUAL_EN enables dual grants.
module regfile_access_ctrl #(
  parameter int LANES         = 16,
  parameter int DW            = 32,
  parameter int AW            = 5,
  parameter int WW            = 4,
  parameter int WB_STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [WW-1:0]         iss_warp,
  input  logic [AW-1:0]         iss_rs1,
  input  logic [AW-1:0]         iss_rs2,
  input  logic [LANES-1:0]      iss_mask,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [WW-1:0]         wb_warp,
  input  logic [AW-1:0]         wb_rd,
  input  logic [LANES-1:0]      wb_mask,
  input  logic [LANES*DW-1:0]   wb_data,
  output logic [WW-1:0]         rb_warp_selector,
  output logic [LANES-1:0]      rb_read_en_0,
  output logic [LANES-1:0]      rb_read_en_1,
  output logic [LANES-1:0]      rb_write_en,
  output logic [AW-1:0]         rb_raddr_0,
  output logic [AW-1:0]         rb_raddr_1,
  output logic [AW-1:0]         rb_waddr,
  output logic [LANES*DW-1:0]   rb_wdata,
  input  logic [LANES*DW-1:0]   rb_rdata_0,
  input  logic [LANES*DW-1:0]   rb_rdata_1,
  output logic                  opr_valid,
  input  logic                  opr_ready,
  output logic [WW-1:0]         opr_warp,
  output logic [LANES-1:0]      opr_mask,
  output logic [LANES*DW-1:0]   opr_a,
  output logic [LANES*DW-1:0]   opr_b
);

  localparam logic [3:0] STREAK_MAX = 4'(WB_STREAK_MAX);

  logic                rd_ok;
  logic                rd_gnt;
  logic                wr_gnt;
  logic                dual_gnt;
  logic [3:0]          streak_q, streak_d;
  logic [WW-1:0]       sel_q;
  logic [AW-1:0]       raddr0_q, raddr1_q, waddr_q;
  logic [LANES*DW-1:0] wdata_q;
  logic                opr_valid_q;
  logic [WW-1:0]       opr_warp_q;
  logic [LANES-1:0]    opr_mask_q;
  logic [LANES*DW-1:0] opr_a_q, opr_a_d;
  logic [LANES*DW-1:0] opr_b_q, opr_b_d;

  // A fetch can be taken only if the operand register is empty or being popped this cycle.
  assign rd_ok = iss_valid && (!opr_valid_q || opr_ready);

  // Arbitration: writes first, except a pending read wins once the write streak hits its cap.
  always_comb begin
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    dual_gnt = 1'b0;
    if (!rst) begin
`ifdef RAC_SAME_WARP_DUAL_EN
      dual_gnt = wb_valid && rd_ok && (wb_warp == iss_warp) &&
                 (((wb_rd != iss_rs1) && (wb_rd != iss_rs2)) || ((wb_mask & iss_mask) == '0));
`endif
      if (dual_gnt) begin
        rd_gnt = 1'b1;
        wr_gnt = 1'b1;
      end else if (wb_valid && !(rd_ok && (streak_q == STREAK_MAX))) begin
        wr_gnt = 1'b1;
      end else if (rd_ok) begin
        rd_gnt = 1'b1;
      end
    end
  end

  assign iss_ready = rd_gnt;
  assign wb_ready  = wr_gnt;

  // Streak counts writes that overtook a waiting read; any read grant or idle issue side clears it.
  always_comb begin
    streak_d = streak_q;
    if (!iss_valid || rd_gnt) begin
      streak_d = '0;
    end else if (wr_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // Register-block drive: granted side drives the bus, otherwise addresses/data hold last values.
  always_comb begin
    rb_warp_selector = sel_q;
    rb_raddr_0       = raddr0_q;
    rb_raddr_1       = raddr1_q;
    rb_waddr         = waddr_q;
    rb_wdata         = wdata_q;
    rb_read_en_0     = '0;
    rb_read_en_1     = '0;
    rb_write_en      = '0;
    if (wr_gnt) begin
      rb_warp_selector = wb_warp;
      rb_waddr         = wb_rd;
      rb_write_en      = wb_mask;
      rb_wdata         = wb_data;
    end
    if (rd_gnt) begin
      rb_warp_selector = iss_warp;
      rb_raddr_0       = iss_rs1;
      rb_raddr_1       = iss_rs2;
      rb_read_en_0     = iss_mask;
      rb_read_en_1     = iss_mask;
    end
  end

  // Inactive lanes of a fetch return zero rather than whatever the register block drives.
  always_comb begin
    opr_a_d = '0;
    opr_b_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (iss_mask[l]) begin
        opr_a_d[l*DW +: DW] = rb_rdata_0[l*DW +: DW];
        opr_b_d[l*DW +: DW] = rb_rdata_1[l*DW +: DW];
      end
    end
  end

  // Hold the last driven bus values and the streak count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      raddr0_q <= '0;
      raddr1_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      streak_q <= '0;
    end else begin
      sel_q    <= rb_warp_selector;
      raddr0_q <= rb_raddr_0;
      raddr1_q <= rb_raddr_1;
      waddr_q  <= rb_waddr;
      wdata_q  <= rb_wdata;
      streak_q <= streak_d;
    end
  end

  // Operand register: a read grant loads (also when popping the same cycle), a pop alone empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr_valid_q <= 1'b0;
      opr_warp_q  <= '0;
      opr_mask_q  <= '0;
      opr_a_q     <= '0;
      opr_b_q     <= '0;
    end else if (rd_gnt) begin
      opr_valid_q <= 1'b1;
      opr_warp_q  <= iss_warp;
      opr_mask_q  <= iss_mask;
      opr_a_q     <= opr_a_d;
      opr_b_q     <= opr_b_d;
    end else if (opr_valid_q && opr_ready) begin
      opr_valid_q <= 1'b0;
    end
  end

  assign opr_valid = opr_valid_q;
  assign opr_warp  = opr_warp_q;
  assign opr_mask  = opr_mask_q;
  assign opr_a     = opr_a_q;
  assign opr_b     = opr_b_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a behavioural register_block and an operand scoreboard.
// Expected operands are computed from a bench-side shadow of accepted writebacks.
// Build with +define+RAC_SAME_WARP_DUAL_EN to exercise the dual-grant variant.
`timescale 1ns/1ps
module tb_regfile_access_ctrl;
  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int WW    = 4;
  localparam int SMAX  = 4;
  localparam int NMEM  = 16 * 32 * 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                iss_valid, iss_ready;
  logic [WW-1:0]       iss_warp;
  logic [AW-1:0]       iss_rs1, iss_rs2;
  logic [LANES-1:0]    iss_mask;
  logic                wb_valid, wb_ready;
  logic [WW-1:0]       wb_warp;
  logic [AW-1:0]       wb_rd;
  logic [LANES-1:0]    wb_mask;
  logic [LANES*DW-1:0] wb_data;
  logic [WW-1:0]       rb_warp_selector;
  logic [LANES-1:0]    rb_read_en_0, rb_read_en_1, rb_write_en;
  logic [AW-1:0]       rb_raddr_0, rb_raddr_1, rb_waddr;
  logic [LANES*DW-1:0] rb_wdata, rb_rdata_0, rb_rdata_1;
  logic                opr_valid, opr_ready;
  logic [WW-1:0]       opr_warp;
  logic [LANES-1:0]    opr_mask;
  logic [LANES*DW-1:0] opr_a, opr_b;

  regfile_access_ctrl #(
    .LANES(LANES), .DW(DW), .AW(AW), .WW(WW), .WB_STREAK_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp(iss_warp),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_mask(iss_mask),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp),
    .wb_rd(wb_rd), .wb_mask(wb_mask), .wb_data(wb_data),
    .rb_warp_selector(rb_warp_selector),
    .rb_read_en_0(rb_read_en_0), .rb_read_en_1(rb_read_en_1), .rb_write_en(rb_write_en),
    .rb_raddr_0(rb_raddr_0), .rb_raddr_1(rb_raddr_1), .rb_waddr(rb_waddr),
    .rb_wdata(rb_wdata), .rb_rdata_0(rb_rdata_0), .rb_rdata_1(rb_rdata_1),
    .opr_valid(opr_valid), .opr_ready(opr_ready), .opr_warp(opr_warp),
    .opr_mask(opr_mask), .opr_a(opr_a), .opr_b(opr_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0]       warp;
    logic [LANES-1:0]    mask;
    logic [LANES*DW-1:0] a;
    logic [LANES*DW-1:0] b;
  } opr_t;

  opr_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        mem_init;
  logic        s_wb_rdy, s_iss_rdy;
  logic [DW-1:0] mem  [0:NMEM-1];
  logic [DW-1:0] gold [0:NMEM-1];

  function automatic int idx(input logic [WW-1:0] w, input logic [AW-1:0] r, input int l);
    return int'(w) * 512 + int'(r) * 16 + l;
  endfunction

  function automatic logic [LANES*DW-1:0] mkdata(input logic [DW-1:0] base, input int step);
    logic [LANES*DW-1:0] d;
    d = '0;
    for (int l = 0; l < LANES; l++) d[l*DW +: DW] = base + DW'(l * step);
    return d;
  endfunction

  // Behavioural register_block: lane-masked write on the edge, combinational reads.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < NMEM; j++) mem[j] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (rb_write_en[l]) mem[idx(rb_warp_selector, rb_waddr, l)] <= rb_wdata[l*DW +: DW];
    end
  end

  // Disabled read lanes return a poison pattern.
  always_comb begin
    rb_rdata_0 = '0;
    rb_rdata_1 = '0;
    for (int l = 0; l < LANES; l++) begin
      rb_rdata_0[l*DW +: DW] = rb_read_en_0[l] ? mem[idx(rb_warp_selector, rb_raddr_0, l)] : 32'hDEADBEEF;
      rb_rdata_1[l*DW +: DW] = rb_read_en_1[l] ? mem[idx(rb_warp_selector, rb_raddr_1, l)] : 32'hDEADBEEF;
    end
  end

  // One clock: sample at the falling edge, run the scoreboard, then return just after the rising edge.
  task automatic cycle();
    opr_t e;
    opr_t got;
    int   bad;
    @(negedge clk);
    s_wb_rdy  = wb_ready;
    s_iss_rdy = iss_ready;
    if (!rst) begin
      if (opr_valid && opr_ready) begin
        n_cmp++;
        got = {opr_warp, opr_mask, opr_a, opr_b};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: operand warp %0d mask %h popped, none expected", opr_warp, opr_mask);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            bad = 0;
            for (int l = LANES - 1; l >= 0; l--)
              if (got.a[l*DW +: DW] !== e.a[l*DW +: DW] || got.b[l*DW +: DW] !== e.b[l*DW +: DW]) bad = l;
            $display("FAIL sb_operand: lane %0d got warp %0d mask %h a %h b %h, want warp %0d mask %h a %h b %h",
                     bad, got.warp, got.mask, got.a[bad*DW +: DW], got.b[bad*DW +: DW],
                     e.warp, e.mask, e.a[bad*DW +: DW], e.b[bad*DW +: DW]);
          end
        end
      end
      if (iss_valid && iss_ready) begin
        e.warp = iss_warp;
        e.mask = iss_mask;
        e.a    = '0;
        e.b    = '0;
        for (int l = 0; l < LANES; l++) begin
          if (iss_mask[l]) begin
            e.a[l*DW +: DW] = gold[idx(iss_warp, iss_rs1, l)];
            e.b[l*DW +: DW] = gold[idx(iss_warp, iss_rs2, l)];
          end
        end
        exp_q.push_back(e);
      end
      if (wb_valid && wb_ready) begin
        for (int l = 0; l < LANES; l++)
          if (wb_mask[l]) gold[idx(wb_warp, wb_rd, l)] = wb_data[l*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [WW-1:0] w, input logic [AW-1:0] r,
                          input logic [LANES-1:0] m, input logic [LANES*DW-1:0] d);
    int n;
    n = 0;
    wb_valid = 1'b1; wb_warp = w; wb_rd = r; wb_mask = m; wb_data = d;
    do begin cycle(); n++; end while (!s_wb_rdy && n < 50);
    n_cmp++;
    if (!s_wb_rdy) begin
      n_err++;
      $display("FAIL wr_timeout: wb_ready=%0b after %0d cycles, want 1", s_wb_rdy, n);
    end
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    iss_valid = 1'b1; wb_valid = 1'b1; wb_mask = 16'hFFFF;
    #1;
    n_cmp++;
    if (opr_valid !== 1'b0 || iss_ready !== 1'b0 || wb_ready !== 1'b0 || rb_write_en !== '0 ||
        rb_read_en_0 !== '0 || rb_warp_selector !== '0 || rb_waddr !== '0 || rb_wdata !== '0 ||
        opr_a !== '0 || opr_mask !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: opr_valid %0b iss_rdy %0b wb_rdy %0b wen %h sel %0d, want all 0",
               opr_valid, iss_ready, wb_ready, rb_write_en, rb_warp_selector);
    end
    iss_valid = 1'b0; wb_valid = 1'b0;
    @(posedge clk);
    cycle();
    mem_init = 1'b0;
    rst = 1'b0;
    wb_valid = 1'b1; wb_warp = 4'd15; wb_rd = 5'd31; wb_mask = 16'hFFFF; wb_data = '1;
    #2;
    n_cmp++;
    if (rb_write_en !== 16'hFFFF || wb_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_write: wen %h wb_rdy %0b, want FFFF 1", rb_write_en, wb_ready);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (rb_write_en !== 16'h0000 || wb_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async_wen: wen %h wb_rdy %0b, want 0000 0", rb_write_en, wb_ready);
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    rst = 1'b0;
    n_cmp++;
    if (mem[idx(4'd15, 5'd31, 0)] !== '0 || mem[idx(4'd15, 5'd31, 15)] !== '0) begin
      n_err++;
      $display("FAIL reset_no_write: mem lane0 %h lane15 %h, want 0", mem[idx(4'd15, 5'd31, 0)], mem[idx(4'd15, 5'd31, 15)]);
    end
    n_cmp++;
    if (opr_valid !== 1'b0 || dut.streak_q !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release: opr_valid %0b streak %0d, want 0 0", opr_valid, dut.streak_q);
    end
  endtask

  task automatic test_write_read();
    do_write(4'd3, 5'd7, 16'hFFFF, mkdata(32'hA5A50000, 1));
    iss_valid = 1'b1; iss_warp = 4'd3; iss_rs1 = 5'd7; iss_rs2 = 5'd7; iss_mask = 16'hFFFF;
    cycle();
    iss_valid = 1'b0;
    n_cmp++;
    if (s_iss_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL wr_rd_grant: iss_ready %0b, want 1", s_iss_rdy);
    end
    n_cmp++;
    if (opr_valid !== 1'b1 || opr_a[31:0] !== 32'hA5A50000 || opr_b[15*DW +: DW] !== 32'hA5A5000F) begin
      n_err++;
      $display("FAIL wr_rd_latency: opr_valid %0b a0 %h b15 %h, want 1 a5a50000 a5a5000f",
               opr_valid, opr_a[31:0], opr_b[15*DW +: DW]);
    end
    cycle();
  endtask

  task automatic test_masked_fetch();
    iss_valid = 1'b1; iss_warp = 4'd3; iss_rs1 = 5'd7; iss_rs2 = 5'd7; iss_mask = 16'h00FF;
    cycle();
    iss_valid = 1'b0;
    n_cmp++;
    if (s_iss_rdy !== 1'b1 || opr_mask !== 16'h00FF || opr_a[LANES*DW-1:8*DW] !== '0 ||
        opr_b[LANES*DW-1:8*DW] !== '0 || opr_a[7*DW +: DW] !== 32'hA5A50007) begin
      n_err++;
      $display("FAIL masked_fetch: rdy %0b mask %h a_hi %h a7 %h, want 1 00ff 0 a5a50007",
               s_iss_rdy, opr_mask, opr_a[LANES*DW-1:8*DW], opr_a[7*DW +: DW]);
    end
    do_write(4'd3, 5'd9, 16'h5A5A, mkdata(32'h12340000, 3));
    iss_valid = 1'b1; iss_rs1 = 5'd9; iss_rs2 = 5'd7; iss_mask = 16'hFFFF;
    cycle();
    iss_valid = 1'b0;
    cycle();
  endtask

  task automatic test_starvation();
    logic exp_w;
    wb_valid = 1'b1; wb_warp = 4'd1; wb_rd = 5'd1; wb_mask = 16'hFFFF; wb_data = mkdata(32'h77000000, 5);
    iss_valid = 1'b1; iss_warp = 4'd3; iss_rs1 = 5'd7; iss_rs2 = 5'd9; iss_mask = 16'hFFFF;
    for (int k = 0; k < 15; k++) begin
      cycle();
      exp_w = ((k % 5) != 4);
      n_cmp++;
      if (s_wb_rdy !== exp_w || s_iss_rdy !== !exp_w) begin
        n_err++;
        $display("FAIL starvation cycle %0d: wb_rdy %0b iss_rdy %0b, want %0b %0b", k, s_wb_rdy, s_iss_rdy, exp_w, !exp_w);
      end
    end
    wb_valid = 1'b0; iss_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    opr_t held;
    logic [LANES*DW-1:0] wd;
    opr_ready = 1'b0;
    iss_valid = 1'b1; iss_warp = 4'd3; iss_rs1 = 5'd9; iss_rs2 = 5'd7; iss_mask = 16'hF0F0;
    cycle();
    n_cmp++;
    if (s_iss_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first_grant: iss_ready %0b, want 1", s_iss_rdy);
    end
    held = {opr_warp, opr_mask, opr_a, opr_b};
    wd = mkdata(32'hBEE00000, 7);
    iss_rs1 = 5'd7; iss_mask = 16'h0F0F;
    wb_valid = 1'b1; wb_warp = 4'd4; wb_rd = 5'd2; wb_mask = 16'hFFFF; wb_data = wd;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_cmp++;
      if (s_iss_rdy !== 1'b0 || s_wb_rdy !== 1'b1 || opr_valid !== 1'b1 ||
          {opr_warp, opr_mask, opr_a, opr_b} !== held || opr_mask !== 16'hF0F0) begin
        n_err++;
        $display("FAIL bp_stall cycle %0d: iss_rdy %0b wb_rdy %0b opr_valid %0b mask %h, want 0 1 1 f0f0 (stable)",
                 k, s_iss_rdy, s_wb_rdy, opr_valid, opr_mask);
      end
    end
    wb_valid = 1'b0;
    n_cmp++;
    if (mem[idx(4'd4, 5'd2, 3)] !== wd[3*DW +: DW]) begin
      n_err++;
      $display("FAIL bp_write_done: mem %h, want %h", mem[idx(4'd4, 5'd2, 3)], wd[3*DW +: DW]);
    end
    opr_ready = 1'b1;
    cycle();
    iss_valid = 1'b0;
    n_cmp++;
    if (s_iss_rdy !== 1'b1 || opr_valid !== 1'b1 || opr_mask !== 16'h0F0F) begin
      n_err++;
      $display("FAIL bp_pop_reload: iss_rdy %0b opr_valid %0b mask %h, want 1 1 0f0f", s_iss_rdy, opr_valid, opr_mask);
    end
    cycle();
  endtask

  task automatic test_dual();
    logic exp_dual;
    logic [LANES*DW-1:0] nd;
`ifdef RAC_SAME_WARP_DUAL_EN
    exp_dual = 1'b1;
`else
    exp_dual = 1'b0;
`endif
    wb_valid = 1'b1; wb_warp = 4'd2; wb_rd = 5'd4; wb_mask = 16'hFFFF; wb_data = mkdata(32'h44440000, 1);
    iss_valid = 1'b1; iss_warp = 4'd2; iss_rs1 = 5'd5; iss_rs2 = 5'd6; iss_mask = 16'hFFFF;
    cycle();
    wb_valid = 1'b0;
    n_cmp++;
    if (s_wb_rdy !== 1'b1 || s_iss_rdy !== exp_dual) begin
      n_err++;
      $display("FAIL dual_disjoint: wb_rdy %0b iss_rdy %0b, want 1 %0b", s_wb_rdy, s_iss_rdy, exp_dual);
    end
    if (!s_iss_rdy) cycle();
    iss_valid = 1'b0;
    cycle();
    nd = mkdata(32'h55550000, 2);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_mask = 16'h00FF; wb_data = nd;
    iss_valid = 1'b1; iss_rs1 = 5'd5; iss_rs2 = 5'd4; iss_mask = 16'h0FF0;
    cycle();
    wb_valid = 1'b0;
    n_cmp++;
    if (s_wb_rdy !== 1'b1 || s_iss_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL dual_conflict: wb_rdy %0b iss_rdy %0b, want 1 0", s_wb_rdy, s_iss_rdy);
    end
    cycle();
    iss_valid = 1'b0;
    n_cmp++;
    if (s_iss_rdy !== 1'b1 || opr_a[4*DW +: DW] !== nd[4*DW +: DW] || opr_a[8*DW +: DW] !== '0) begin
      n_err++;
      $display("FAIL dual_raw: iss_rdy %0b a4 %h a8 %h, want 1 %h 0", s_iss_rdy, opr_a[4*DW +: DW], opr_a[8*DW +: DW], nd[4*DW +: DW]);
    end
    cycle();
  endtask

  initial begin
    mem_init  = 1'b1;
    opr_ready = 1'b1;
    iss_valid = 1'b0; iss_warp = '0; iss_rs1 = '0; iss_rs2 = '0; iss_mask = '0;
    wb_valid  = 1'b0; wb_warp = '0; wb_rd = '0; wb_mask = '0; wb_data = '0;
    s_wb_rdy  = 1'b0; s_iss_rdy = 1'b0;
    for (int j = 0; j < NMEM; j++) gold[j] = '0;
    test_reset();
    test_write_read();
    test_masked_fetch();
    test_starvation();
    test_backpressure();
    test_dual();
    cycle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d operands never delivered, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
